// File: rtl/sb_pkg.sv
// sb_pkg: shared types and defaults for the sideband transmit path.
// SB_TX_PARITY_EN (optional define) selects the appended even-parity bit.
package sb_pkg;

    localparam int SB_MSG_W_DEFAULT  = 64;
    localparam int SB_GAP_UI_DEFAULT = 32;
    // Widest message the parity helper covers; narrower messages are zero-extended.
    localparam int SB_PAR_MAX_W      = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } sb_tx_state_e;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic sb_even_parity(input logic [SB_PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sb_sync_fifo.sv
// sb_sync_fifo: MSG_W x DEPTH single-clock message FIFO.
// A push is refused when full even if a pop happens in the same cycle.
module sb_sync_fifo #(
    parameter int MSG_W = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk_800MHz,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [MSG_W-1:0]           push_data,
    input  logic                       pop,
    output logic [MSG_W-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [MSG_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    level_nxt;
    logic             do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Occupancy after this cycle's push/pop.
    always_comb begin
        level_nxt = level;
        if (do_push && !do_pop)      level_nxt = level + LW'(1);
        else if (do_pop && !do_push) level_nxt = level - LW'(1);
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_800MHz) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointers wrap modulo DEPTH (power of two); flags registered from the next level.
    always_ff @(posedge clk_800MHz or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level_nxt;
            full  <= (level_nxt == LW'(DEPTH));
            empty <= (level_nxt == '0);
        end
    end

endmodule

// File: rtl/sb_tx_framer.sv
// sb_tx_framer: buffers sideband messages and serialises them MSB-first
// with a forwarded clock (1 UI = 2 cycles) and an idle gap between frames.
// Optional define SB_TX_PARITY_EN appends an even-parity bit to each frame.
module sb_tx_framer
    import sb_pkg::*;
#(
    parameter int MSG_W  = SB_MSG_W_DEFAULT,
    parameter int DEPTH  = 4,
    parameter int GAP_UI = SB_GAP_UI_DEFAULT
) (
    input  logic                       clk_800MHz,
    input  logic                       reset_n,
    input  logic                       enable_i,
    input  logic [MSG_W-1:0]           data_i,
    input  logic                       valid_i,
    output logic                       data_valid_ack_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                       busy_o,
    output logic                       dataPin_o,
    output logic                       clkPin_o
);

`ifdef SB_TX_PARITY_EN
    localparam int FRAME_W = MSG_W + 1;
`else
    localparam int FRAME_W = MSG_W;
`endif
    localparam int BW = $clog2(FRAME_W+1);
    localparam int GW = $clog2(GAP_UI+1);

    sb_tx_state_e     state_q, state_d;
    logic             phase_q, phase_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d, frame;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic             data_d, clk_d, busy_d;
    logic             push, pop, fifo_empty;
    logic [MSG_W-1:0] head;

    // Ack is registered, so a held valid_i cannot be taken twice in a row.
    assign push = valid_i && !full_o && !data_valid_ack_o;

    sb_sync_fifo #(.MSG_W(MSG_W), .DEPTH(DEPTH)) u_fifo (
        .clk_800MHz (clk_800MHz),
        .reset_n    (reset_n),
        .push       (push),
        .push_data  (data_i),
        .pop        (pop),
        .head       (head),
        .full       (full_o),
        .empty      (fifo_empty),
        .level      (level_o)
    );

`ifdef SB_TX_PARITY_EN
    assign frame = {head, sb_even_parity(SB_PAR_MAX_W'(head))};
`else
    assign frame = head;
`endif

    // Next-state and next-pin logic. The pin register holds the current bit,
    // so shreg carries only the bits still to be sent, MSB next.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        data_d    = dataPin_o;
        clk_d     = 1'b0;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                data_d = 1'b0;
                if (enable_i && !fifo_empty) begin
                    pop       = 1'b1;
                    data_d    = frame[FRAME_W-1];
                    shreg_d   = frame << 1;
                    bit_cnt_d = BW'(FRAME_W);
                    phase_d   = 1'b0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                    clk_d   = 1'b1;
                end else begin
                    phase_d   = 1'b0;
                    bit_cnt_d = bit_cnt_q - BW'(1);
                    if (bit_cnt_q == BW'(1)) begin
                        data_d    = 1'b0;
                        gap_cnt_d = GW'(GAP_UI);
                        state_d   = GAP;
                    end else begin
                        data_d  = shreg_q[FRAME_W-1];
                        shreg_d = shreg_q << 1;
                    end
                end
            end
            GAP: begin
                data_d  = 1'b0;
                phase_d = ~phase_q;
                if (phase_q) begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                    if (gap_cnt_q == GW'(1)) state_d = IDLE;
                end
            end
            default: begin
                data_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, datapath and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk_800MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            phase_q          <= 1'b0;
            shreg_q          <= '0;
            bit_cnt_q        <= '0;
            gap_cnt_q        <= '0;
            data_valid_ack_o <= 1'b0;
            busy_o           <= 1'b0;
            dataPin_o        <= 1'b0;
            clkPin_o         <= 1'b0;
        end else begin
            state_q          <= state_d;
            phase_q          <= phase_d;
            shreg_q          <= shreg_d;
            bit_cnt_q        <= bit_cnt_d;
            gap_cnt_q        <= gap_cnt_d;
            data_valid_ack_o <= push;
            busy_o           <= busy_d;
            dataPin_o        <= data_d;
            clkPin_o         <= clk_d;
        end
    end

endmodule
